// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port, 1-cycle synchronous memory between an instruction
// fetch port (i_*) and a load/store data port (d_*). Grants are combinational
// from the requests, so an uncontended request is accepted in the same cycle
// it is raised. The response (rvalid plus data) follows one cycle later. A new
// grant may be issued every cycle, so the port can run at full throughput.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : on contention, grant the side that was not granted last.
//               The last-grant history resets to "data", so fetch wins the
//               first contention after reset.
//   undefined : fixed priority. The data side always wins contention.
//
// Parameters
//   AW     address width of both requester ports and the memory port
//   CNT_W  width of the saturating contention counter
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   i_req/i_addr          fetch request (held until granted)
//   i_gnt                 fetch accepted this cycle
//   i_rvalid/i_rdata      fetch data, one cycle after i_gnt
//   d_req/d_addr/d_we/    data request; d_we are byte strobes (0 = load)
//   d_wdata
//   d_gnt                 data request accepted this cycle
//   d_rvalid/d_rdata      load data / store done, one cycle after d_gnt
//   m_en/m_addr/m_we/     memory request, driven by the granted side
//   m_wdata
//   m_rdata               memory read data, valid the cycle after m_en
//   conflict_cnt          cycles in which some request waited (saturating)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int AW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             i_req,
  input  logic [AW-1:0]    i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,

  input  logic             d_req,
  input  logic [AW-1:0]    d_addr,
  input  logic [3:0]       d_we,
  input  logic [31:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,

  output logic             m_en,
  output logic [AW-1:0]    m_addr,
  output logic [3:0]       m_we,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata,

  output logic [CNT_W-1:0] conflict_cnt
);

  // Owner of the response arriving from memory this cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } resp_state_e;

  resp_state_e state;
  logic        waiting;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the most recent grant went to the data side.
  logic last_gnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // each path assigns it and no latch is inferred.
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (last_gnt_d) i_gnt = 1'b1;
        else            d_gnt = 1'b1;
`else
        d_gnt = 1'b1;
`endif
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  // A request is waiting when it is raised but was not granted this cycle.
  assign waiting = (i_req && !i_gnt) || (d_req && !d_gnt);

  // ---------------------------------------------------------------------------
  // Memory port: driven by whichever side was granted. With no grant, m_we is
  // forced low so a stray strobe never reaches memory.
  // ---------------------------------------------------------------------------
  assign m_en    = i_gnt || d_gnt;
  assign m_addr  = d_gnt ? d_addr : i_addr;
  assign m_we    = d_gnt ? d_we   : 4'h0;
  assign m_wdata = d_wdata;

  // ---------------------------------------------------------------------------
  // Responses. Read data is shared and qualified only by rvalid. Gating rvalid
  // with reset drops a response that was in flight when reset arrived.
  // ---------------------------------------------------------------------------
  assign i_rvalid = (state == RESP_I) && !reset;
  assign d_rvalid = (state == RESP_D) && !reset;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

  // ---------------------------------------------------------------------------
  // State: response owner, contention counter, arbitration history
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments. Every flop then samples
    // its pre-edge inputs, regardless of statement order or of other blocks.
    if (reset) begin
      state        <= IDLE;
      conflict_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_d   <= 1'b1;
`endif
    end else begin
      if (i_gnt)      state <= RESP_I;
      else if (d_gnt) state <= RESP_D;
      else            state <= IDLE;

      if (waiting && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + 1'b1;

`ifdef ARB_ROUND_ROBIN_EN
      if (i_gnt)      last_gnt_d <= 1'b0;
      else if (d_gnt) last_gnt_d <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. It contains:
//   - a behavioural 1-cycle synchronous memory attached to the m_* port;
//   - a reference model that decides, from the arbitration rules, which side
//     should win each cycle. It checks the grant, the memory request and the
//     contention count, and queues the expected response for each port;
//   - a monitor that pops those queues when a response is due and compares
//     rvalid and load data;
//   - directed sequences for the documented scenarios, then randomized traffic
//     with occasional resets.
// The DUT is built with CNT_W = 4 so that counter saturation is reachable.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int AW    = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             i_req, d_req;
  logic [AW-1:0]    i_addr, d_addr;
  logic [3:0]       d_we;
  logic [31:0]      d_wdata;
  logic             i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [31:0]      i_rdata, d_rdata;
  logic             m_en;
  logic [AW-1:0]    m_addr;
  logic [3:0]       m_we;
  logic [31:0]      m_wdata;
  logic [31:0]      m_rdata = '0;
  logic [CNT_W-1:0] conflict_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .conflict_cnt(conflict_cnt)
  );

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    return 32'h1000_0001 * i[31:0] ^ 32'hA5C3_0F00;
  endfunction

  function automatic int widx(input logic [AW-1:0] a);
    return int'(a[9:2]);
  endfunction

  // ---------------------------------------------------------------------------
  // Environment memory: read-before-write, 1-cycle latency
  // ---------------------------------------------------------------------------
  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (m_en) begin
      m_rdata <= mem[widx(m_addr)];
      for (int b = 0; b < 4; b++)
        if (m_we[b]) mem[widx(m_addr)][b*8 +: 8] <= m_wdata[b*8 +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int          cyc;
    bit          is_load;
    logic [31:0] data;
  } resp_t;

  logic [31:0] ref_mem [256];
  resp_t       iq[$];
  resp_t       dq[$];
  int          cyc = 0;
  bit          last_was_i = 1'b0;  // history resets to "data granted last"
  int          exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Model: decide the winner from the arbitration rules and predict everything
  // visible in this cycle.
  always @(negedge clk) begin
    bit ei, ed;
    ei = 1'b0;
    ed = 1'b0;
    if (reset) begin
      check("gnt_during_reset", {i_gnt, d_gnt, m_en, m_we}, 64'h0);
      last_was_i = 1'b0;
      exp_cnt    = 0;
    end else begin
      if (i_req && d_req) begin
        if (RR && !last_was_i) ei = 1'b1;
        else                   ed = 1'b1;
      end else begin
        ei = i_req;
        ed = d_req;
      end
      check("conflict_cnt", conflict_cnt, exp_cnt);
      check("grant", {i_gnt, d_gnt}, {ei, ed});
      check("m_en", m_en, ei | ed);
      if (!ei && !ed) check("m_we_idle", m_we, 4'h0);
      if (ei) begin
        check("m_addr_fetch", m_addr, i_addr);
        check("m_we_fetch", m_we, 4'h0);
        iq.push_back('{cyc, 1'b1, ref_mem[widx(i_addr)]});
        last_was_i = 1'b1;
      end
      if (ed) begin
        check("m_addr_data", m_addr, d_addr);
        check("m_we_data", m_we, d_we);
        if (d_we != 4'h0) check("m_wdata", m_wdata, d_wdata);
        dq.push_back('{cyc, d_we == 4'h0, ref_mem[widx(d_addr)]});
        for (int b = 0; b < 4; b++)
          if (d_we[b]) ref_mem[widx(d_addr)][b*8 +: 8] = d_wdata[b*8 +: 8];
        last_was_i = 1'b0;
      end
      if ((i_req && !ei) || (d_req && !ed))
        if (exp_cnt < CMAX) exp_cnt++;
    end
  end

  // Monitor: a response is due exactly one cycle after its grant.
  always @(negedge clk) begin
    bit exp_i, exp_d;
    if (reset) begin
      check("rvalid_during_reset", {i_rvalid, d_rvalid}, 64'h0);
      iq.delete();
      dq.delete();
    end else begin
      while (iq.size() > 0 && iq[0].cyc < cyc - 1) void'(iq.pop_front());
      while (dq.size() > 0 && dq[0].cyc < cyc - 1) void'(dq.pop_front());
      exp_i = (iq.size() > 0) && (iq[0].cyc == cyc - 1);
      exp_d = (dq.size() > 0) && (dq[0].cyc == cyc - 1);
      check("i_rvalid", i_rvalid, exp_i);
      check("d_rvalid", d_rvalid, exp_d);
      if (exp_i) begin
        if (i_rvalid) check("i_rdata", i_rdata, iq[0].data);
        void'(iq.pop_front());
      end
      if (exp_d) begin
        if (d_rvalid && dq[0].is_load) check("d_rdata", d_rdata, dq[0].data);
        void'(dq.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req   = 1'b0;
    d_req   = 1'b0;
    d_we    = 4'h0;
    i_addr  = '0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] g [4];
    logic [1:0] exp_g;
    bit         gi, gd;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = init_val(i);
      ref_mem[i] = init_val(i);
    end
    idle();
    reset = 1'b1;
    step();
    i_req = 1'b1;
    d_req = 1'b1;
    #1;
    check("reset_gates_gnt", {i_gnt, d_gnt, m_en, m_we}, 64'h0);
    step();
    check("reset_cnt", conflict_cnt, 0);
    check("reset_rvalid", {i_rvalid, d_rvalid}, 64'h0);
    idle();
    reset = 1'b0;

    // Fetch only: same-cycle grant, data one cycle later.
    i_req  = 1'b1;
    i_addr = 32'h10;
    #1;
    check("fetch_gnt", i_gnt, 1'b1);
    check("fetch_m_addr", m_addr, 32'h10);
    check("fetch_m_we", m_we, 4'h0);
    step();
    i_req = 1'b0;
    #1;
    check("fetch_rvalid", i_rvalid, 1'b1);
    check("fetch_rdata", i_rdata, init_val(4));
    step();

    // Store then load at the same address.
    d_req   = 1'b1;
    d_addr  = 32'h40;
    d_we    = 4'hF;
    d_wdata = 32'hDEAD_BEEF;
    #1;
    check("store_gnt", d_gnt, 1'b1);
    step();
    d_we = 4'h0;
    #1;
    check("store_done", d_rvalid, 1'b1);
    check("load_gnt", d_gnt, 1'b1);
    step();
    d_req = 1'b0;
    #1;
    check("load_rvalid", d_rvalid, 1'b1);
    check("load_rdata", d_rdata, 32'hDEAD_BEEF);
    step();

    // Both sides requesting for four cycles, from a fresh reset.
    do_reset(2);
    i_req  = 1'b1;
    i_addr = 32'h8;
    d_req  = 1'b1;
    d_addr = 32'hC;
    for (int k = 0; k < 4; k++) begin
      #1;
      g[k] = {i_gnt, d_gnt};
      step();
    end
    for (int k = 0; k < 4; k++) begin
      exp_g = (RR && (k % 2 == 0)) ? 2'b10 : 2'b01;
      check($sformatf("contention_grant_%0d", k), g[k], exp_g);
    end
    idle();
    #1;
    check("contention_cnt4", conflict_cnt, 4);

    // Reset arriving the cycle after a data grant drops the response.
    d_req  = 1'b1;
    d_addr = 32'h20;
    #1;
    check("pre_reset_gnt", d_gnt, 1'b1);
    step();
    reset = 1'b1;
    d_req = 1'b0;
    #1;
    check("reset_drop_rvalid", d_rvalid, 1'b0);
    step();
    check("reset_drop_rvalid2", d_rvalid, 1'b0);
    check("reset_clears_cnt", conflict_cnt, 0);
    reset = 1'b0;
    step();
    check("post_reset_idle", {i_rvalid, d_rvalid}, 64'h0);

    // Saturation: 20 cycles of contention on a 4-bit counter.
    i_req = 1'b1;
    d_req = 1'b1;
    repeat (20) step();
    idle();
    #1;
    check("cnt_saturates", conflict_cnt, CMAX);
    step();

    // Randomized traffic: requests held until granted, occasionally dropped,
    // with sporadic resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      gi = i_gnt;
      gd = d_gnt;
      @(posedge clk);
      #1;
      reset = ($urandom_range(0, 199) == 0);
      if (!i_req || gi || $urandom_range(0, 15) == 0) begin
        i_req  = ($urandom_range(0, 2) != 0);
        i_addr = AW'($urandom_range(0, 15)) << 2;
      end
      if (!d_req || gd || $urandom_range(0, 15) == 0) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_addr  = AW'($urandom_range(0, 15)) << 2;
        d_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        d_wdata = $urandom;
      end
      if ($urandom_range(0, 63) == 0) begin
        reset = 1'b1;
      end
    end
    reset = 1'b0;
    idle();
    repeat (4) step();
    check("i_queue_drained", iq.size(), 0);
    check("d_queue_drained", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of both requester ports and the memory port.
REQ-002 Parameter: CNT_W, 16, width of the contention counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_req  input  1  instruction-fetch read request, held until granted.
REQ-006 i_addr  input  AW  fetch byte address.
REQ-007 i_gnt  output  1  fetch request accepted this cycle.
REQ-008 i_rvalid  output  1  fetch data valid, one cycle after i_gnt.
REQ-009 i_rdata  output  32  fetch data.
REQ-010 d_req  input  1  data request, held with address/data/strobe stable until granted.
REQ-011 d_addr  input  AW  data byte address.
REQ-012 d_we  input  4  byte write strobes; 0 = load.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_gnt  output  1  data request accepted this cycle.
REQ-015 d_rvalid  output  1  load data valid / store done, one cycle after d_gnt.
REQ-016 d_rdata  output  32  load data.
REQ-017 m_en  output  1  memory access enable.
REQ-018 m_addr  output  AW  memory address.
REQ-019 m_we  output  4  memory byte write strobes.
REQ-020 m_wdata  output  32  memory write data.
REQ-021 m_rdata  input  32  memory read data, valid the cycle after m_en (1-cycle synchronous memory).
REQ-022 conflict_cnt  output  CNT_W  count of cycles with a pending-but-ungranted request.

Function
REQ-023 At most one of i_gnt/d_gnt asserted per cycle; gnt is combinational from req and arbitration state, no request-to-grant bubble.
REQ-024 Granted requester drives m_addr/m_we/m_wdata; m_en = i_gnt|d_gnt; fetch grant forces m_we=0; no grant forces m_we=0.
REQ-025 Response-owner register, states IDLE, RESP_I, RESP_D: next state RESP_I on i_gnt, RESP_D on d_gnt, else IDLE.
REQ-026 i_rvalid = (state==RESP_I); d_rvalid = (state==RESP_D); i_rdata = d_rdata = m_rdata; data qualified only by rvalid.
REQ-027 Back-to-back grants allowed every cycle; a new grant may coincide with the previous response (full throughput).
REQ-028 Single requester: granted in the same cycle it asserts req.
REQ-029 Both requesting: arbitration per REQ-035/REQ-036; loser keeps req high and is not granted that cycle.
REQ-030 conflict_cnt increments by 1 in each cycle where i_req&!i_gnt or d_req&!d_gnt; saturates at all-ones, no wrap.
REQ-031 A req deasserted before grant is legal and produces no response.

Reset
REQ-032 While reset is high: i_gnt=d_gnt=0, m_en=0, m_we=0 combinationally, regardless of req.
REQ-033 On reset edge: state=IDLE, conflict_cnt=0, last-grant register=D; any in-flight response is dropped (no rvalid in the cycle after reset).
REQ-034 First cycle after reset deasserts: normal arbitration, no extra latency.

Configuration
REQ-035 Macro ARB_ROUND_ROBIN_EN defined: on contention grant the requester not granted last (last-grant register updated on every grant); reset value D so fetch wins the first contention.
REQ-036 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority, data side always wins contention; last-grant register absent; fetch may starve while d_req held.

Verification
REQ-037 Fetch only: i_req=1, i_addr=0x10 one cycle -> i_gnt same cycle, m_addr=0x10, m_we=0; next cycle i_rvalid=1, i_rdata=mem[0x10].
REQ-038 Store then load same address: d_we=0xF, d_wdata=0xDEADBEEF, addr 0x40, then d_we=0 -> d_rvalid on both, load returns 0xDEADBEEF.
REQ-039 Both req held 4 cycles: round-robin build -> grants I,D,I,D, conflict_cnt=4; fixed build -> D,D,D,D, i_gnt never, conflict_cnt=4.
REQ-040 Reset asserted the cycle after a d_gnt -> d_rvalid stays 0, conflict_cnt=0, state IDLE.
REQ-041 CNT_W=4, contention held 20 cycles -> conflict_cnt stops at 15.
